mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter.
// FSM state encoding and access-owner tags.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        RESP    = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one single-outstanding memory port.
// Data wins collisions unless fetch has been starved STARVE_LIMIT times.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH_DATA   = 32,
    parameter int WIDTH_ADDR   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int WAIT_MAX     = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [WIDTH_ADDR-1:0] if_addr,
    output logic [WIDTH_DATA-1:0] if_rdata,
    output logic                  if_ready,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [WIDTH_ADDR-1:0] dm_addr,
    input  logic [WIDTH_DATA-1:0] dm_wdata,
    output logic [WIDTH_DATA-1:0] dm_rdata,
    output logic                  dm_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [WIDTH_ADDR-1:0] mem_addr,
    output logic [WIDTH_DATA-1:0] mem_wdata,
    input  logic [WIDTH_DATA-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  err,
    output logic                  stall_f,
    output logic                  stall_m
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = $clog2(WAIT_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIMIT);
    localparam logic [WW-1:0] WAIT_TOP   = WW'(WAIT_MAX);

    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    logic [WIDTH_ADDR-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [WIDTH_DATA-1:0] wdata_q, wdata_d;
    logic [WIDTH_DATA-1:0] if_rdata_q, if_rdata_d;
    logic [WIDTH_DATA-1:0] dm_rdata_q, dm_rdata_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic [WW-1:0]         wait_q, wait_d;
    logic                  err_q, err_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            starve_q   <= '0;
            wait_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            starve_q   <= starve_d;
            wait_q     <= wait_d;
            err_q      <= err_d;
        end
    end

    always_comb begin : next_state
        logic            grant_if;
        logic [WW-1:0]   wait_inc;
        logic            done;
        logic [WIDTH_DATA-1:0] resp_data;
        grant_if   = 1'b0;
        wait_inc   = wait_q + WW'(1);
        done       = 1'b0;
        resp_data  = '0;
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        starve_d   = starve_q;
        wait_d     = wait_q;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (if_req || dm_req) begin
                    grant_if = if_req &&
                               (!dm_req || starve_q == STARVE_TOP);
                    wait_d   = '0;
                    if (grant_if) begin
                        owner_d  = OWN_IF;
                        addr_d   = if_addr;
                        we_d     = 1'b0;
                        wdata_d  = '0;
                        starve_d = '0;
                        state_d  = BUSY_IF;
                    end else begin
                        owner_d = OWN_DM;
                        addr_d  = dm_addr;
                        we_d    = dm_we;
                        wdata_d = dm_wdata;
                        state_d = BUSY_DM;
                        if (if_req && starve_q != STARVE_TOP)
                            starve_d = starve_q + SW'(1);
                    end
                end
            end
            BUSY_IF, BUSY_DM: begin
                // A late ack on the timeout cycle still counts as success.
                if (mem_ack) begin
                    done      = 1'b1;
                    resp_data = mem_rdata;
                    err_d     = 1'b0;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == WAIT_TOP) begin
                        done  = 1'b1;
                        err_d = 1'b1;
                    end
                end
                if (done) begin
                    state_d = RESP;
                    if (owner_q == OWN_IF) if_rdata_d = resp_data;
                    else                   dm_rdata_d = resp_data;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin : outputs
        mem_req   = (state_q == BUSY_IF) || (state_q == BUSY_DM);
        mem_we    = (state_q == BUSY_DM) && we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if_ready  = (state_q == RESP) && (owner_q == OWN_IF);
        dm_ready  = (state_q == RESP) && (owner_q == OWN_DM);
        err       = (state_q == RESP) && err_q;
        if_rdata  = if_rdata_q;
        dm_rdata  = dm_rdata_q;
    end

    assign stall_f = if_req && !if_ready;
    assign stall_m = dm_req && !dm_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int WD = 32;
    localparam int WA = 32;
    localparam int SL = 4;
    localparam int WM = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, dm_req, dm_we, mem_ack;
    logic [WA-1:0] if_addr, dm_addr;
    logic [WD-1:0] dm_wdata, mem_rdata;
    logic [WD-1:0] if_rdata, dm_rdata, mem_wdata;
    logic [WA-1:0] mem_addr;
    logic          if_ready, dm_ready, mem_req, mem_we;
    logic          err, stall_f, stall_m;

    mem_arbiter #(
        .WIDTH_DATA(WD), .WIDTH_ADDR(WA),
        .STARVE_LIMIT(SL), .WAIT_MAX(WM)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .dm_ready(dm_ready),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .err(err), .stall_f(stall_f), .stall_m(stall_m)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic        dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          d;
        logic        exp_err;
        logic [31:0] exp_rd;
        int          busy;
    } vec_t;

    vec_t tbl [6];

    task automatic chk1(input string nm, input logic act,
                        input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %b want %b",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h want %h",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_access(input vec_t v);
        if_req   = !v.dm;
        dm_req   = v.dm;
        if_addr  = v.dm ? 32'h0 : v.addr;
        dm_addr  = v.dm ? v.addr : 32'h0;
        dm_we    = v.we;
        dm_wdata = v.wdata;
        step();
        for (int k = 0; k < v.busy; k++) begin
            chk1("tbl mem_req", mem_req, 1'b1);
            chk32("tbl mem_addr", mem_addr, v.addr);
            chk1("tbl mem_we", mem_we, v.dm && v.we);
            if (v.dm && v.we) chk32("tbl mem_wdata", mem_wdata, v.wdata);
            mem_ack   = (k == v.d);
            mem_rdata = v.rdata;
            step();
        end
        mem_ack = 1'b0;
        chk1("tbl resp mem_req", mem_req, 1'b0);
        chk1("tbl if_ready", if_ready, !v.dm);
        chk1("tbl dm_ready", dm_ready, v.dm);
        chk1("tbl err", err, v.exp_err);
        chk1("tbl stall", v.dm ? stall_m : stall_f, 1'b0);
        chk32("tbl rdata", v.dm ? dm_rdata : if_rdata, v.exp_rd);
        if_req = 1'b0;
        dm_req = 1'b0;
        step();
        chk1("tbl pulse end", if_ready | dm_ready | err, 1'b0);
        chk32("tbl rdata hold", v.dm ? dm_rdata : if_rdata, v.exp_rd);
    endtask

    logic        m_own, m_we, m_err, if_pend, dm_pend;
    logic [31:0] m_addr, m_wdata, m_rd, m_rd_mem, m_if_rd, m_dm_rd;
    int          m_d, m_grant, m_resp, m_busy, starve, kidx;
    logic        busy, resp;

    initial begin
        rst_n = 1'b0;
        {if_req, dm_req, dm_we, mem_ack} = '0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;

        tbl[0] = '{1'b0, 1'b0, 32'h10, 32'h0, 32'h00500093,
                   0, 1'b0, 32'h00500093, 1};
        tbl[1] = '{1'b1, 1'b0, 32'h80, 32'h0, 32'hCAFEF00D,
                   2, 1'b0, 32'hCAFEF00D, 3};
        tbl[2] = '{1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 32'h11111111,
                   0, 1'b0, 32'h11111111, 1};
        tbl[3] = '{1'b0, 1'b0, 32'h44, 32'h0, 32'h12345678,
                   14, 1'b0, 32'h12345678, 15};
        tbl[4] = '{1'b1, 1'b0, 32'h88, 32'h0, 32'hFFFFFFFF,
                   99, 1'b1, 32'h0, 15};
        tbl[5] = '{1'b0, 1'b0, 32'h4C, 32'h0, 32'hA5A5A5A5,
                   99, 1'b1, 32'h0, 15};

        step();
        step();
        chk1("rst mem_req", mem_req, 1'b0);
        chk1("rst mem_we", mem_we, 1'b0);
        chk1("rst ready", if_ready | dm_ready, 1'b0);
        chk1("rst err", err, 1'b0);
        chk32("rst mem_addr", mem_addr, 32'h0);
        chk32("rst mem_wdata", mem_wdata, 32'h0);
        chk32("rst if_rdata", if_rdata, 32'h0);
        chk32("rst dm_rdata", dm_rdata, 32'h0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) do_access(tbl[i]);

        // Collision: data first, then fetch at the next IDLE.
        if_req = 1'b1; if_addr = 32'h20;
        dm_req = 1'b1; dm_we = 1'b1;
        dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF;
        step();
        chk32("col mem_addr", mem_addr, 32'h40);
        chk1("col mem_we", mem_we, 1'b1);
        chk32("col mem_wdata", mem_wdata, 32'hDEADBEEF);
        mem_ack = 1'b1; mem_rdata = 32'h0;
        step();
        mem_ack = 1'b0;
        chk1("col dm_ready", dm_ready, 1'b1);
        chk1("col if_ready", if_ready, 1'b0);
        chk1("col stall_f", stall_f, 1'b1);
        chk1("col stall_m", stall_m, 1'b0);
        dm_req = 1'b0; dm_we = 1'b0;
        step();
        chk1("col idle mem_req", mem_req, 1'b0);
        step();
        chk1("col if mem_req", mem_req, 1'b1);
        chk32("col if mem_addr", mem_addr, 32'h20);
        chk1("col if mem_we", mem_we, 1'b0);
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        step();
        mem_ack = 1'b0;
        chk1("col if_ready", if_ready, 1'b1);
        chk32("col if_rdata", if_rdata, 32'h0BADF00D);
        if_req = 1'b0;
        step();

        // Starvation: fetch held against continuous data requests.
        if_req = 1'b1; if_addr = 32'h200;
        dm_req = 1'b1; dm_addr = 32'h100; dm_we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk32("starve grant", mem_addr, (i < 4) ? 32'h100 : 32'h200);
            mem_ack = 1'b1; mem_rdata = 32'(i);
            step();
            mem_ack = 1'b0;
            chk1("starve dm_ready", dm_ready, i < 4);
            chk1("starve if_ready", if_ready, i == 4);
            if (i == 4) begin
                if_req = 1'b0;
                dm_req = 1'b0;
            end
            step();
        end

        // Reset in BUSY_IF, then a stray ack after release.
        if_req = 1'b1; if_addr = 32'h30;
        step();
        chk1("rma busy", mem_req, 1'b1);
        rst_n = 1'b0; if_req = 1'b0;
        step();
        rst_n = 1'b1;
        chk1("rma rst mem_req", mem_req, 1'b0);
        step();
        chk1("rma ready1", if_ready, 1'b0);
        step();
        mem_ack = 1'b1; mem_rdata = 32'h77777777;
        chk1("rma mem_req", mem_req, 1'b0);
        step();
        mem_ack = 1'b0;
        chk1("rma ready2", if_ready, 1'b0);
        chk1("rma idle", mem_req, 1'b0);
        step();
        chk1("rma ready3", if_ready, 1'b0);
        chk32("rma if_rdata", if_rdata, 32'h0);

        // Randomized traffic against a transaction-level model.
        m_if_rd = 32'h0; m_dm_rd = 32'h0; starve = 0;
        if_pend = 1'b0; dm_pend = 1'b0;
        m_own = 1'b0; m_we = 1'b0; m_err = 1'b0; m_d = 0;
        m_addr = '0; m_wdata = '0; m_rd = '0; m_rd_mem = '0;
        m_grant = cyc - 2; m_resp = cyc - 1;
        for (int n = 0; n < 3000; n++) begin
            busy = (cyc > m_grant) && (cyc < m_resp);
            resp = (cyc == m_resp);
            chk1("rnd mem_req", mem_req, busy);
            if (busy) begin
                chk32("rnd mem_addr", mem_addr, m_addr);
                chk1("rnd mem_we", mem_we, m_we);
                if (m_we) chk32("rnd mem_wdata", mem_wdata, m_wdata);
            end
            chk1("rnd if_ready", if_ready, resp && !m_own);
            chk1("rnd dm_ready", dm_ready, resp && m_own);
            chk1("rnd err", err, resp && m_err);
            chk1("rnd stall_f", stall_f, if_req && !(resp && !m_own));
            chk1("rnd stall_m", stall_m, dm_req && !(resp && m_own));
            if (resp) begin
                if (m_own) begin m_dm_rd = m_rd; dm_pend = 1'b0; end
                else       begin m_if_rd = m_rd; if_pend = 1'b0; end
            end
            chk32("rnd if_rdata", if_rdata, m_if_rd);
            chk32("rnd dm_rdata", dm_rdata, m_dm_rd);

            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1'b1;
                if_addr = $urandom;
            end
            if (!dm_pend && $urandom_range(0, 2) == 0) begin
                dm_pend  = 1'b1;
                dm_addr  = $urandom;
                dm_we    = 1'($urandom_range(0, 1));
                dm_wdata = $urandom;
            end
            if_req = if_pend;
            dm_req = dm_pend;

            kidx = cyc - m_grant - 1;
            if (busy && kidx == m_d) begin
                mem_ack = 1'b1; mem_rdata = m_rd_mem;
            end else begin
                mem_ack   = busy ? 1'b0 : 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end

            if (cyc > m_resp && (if_req || dm_req)) begin
                if (if_req && dm_req) m_own = (starve != SL);
                else                  m_own = dm_req;
                if (!m_own)      starve = 0;
                else if (if_req) starve = (starve < SL) ? starve + 1 : SL;
                m_addr  = m_own ? dm_addr : if_addr;
                m_we    = m_own && dm_we;
                m_wdata = dm_wdata;
                if ($urandom_range(0, 7) == 0)
                    m_d = WM + int'($urandom_range(0, 3));
                else if ($urandom_range(0, 15) == 0)
                    m_d = WM - 1;
                else
                    m_d = int'($urandom_range(0, 4));
                m_rd_mem = $urandom;
                m_err    = (m_d >= WM);
                m_rd     = m_err ? 32'h0 : m_rd_mem;
                m_busy   = m_err ? WM : m_d + 1;
                m_grant  = cyc;
                m_resp   = cyc + 1 + m_busy;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
